// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the sequential signed multiplier
//
// Purpose: controller state encoding and the default operand width used by
//          seq_mult_ctrl and shift_add_dp.
// Contents: state_t (IDLE, RUN, SIGN, DONE; 2-bit), DEFAULT_WIDTH.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_dp.sv
// rtl/shift_add_dp.sv - sign-magnitude shift-add datapath for the sequential multiplier
//
// Purpose: holds operand magnitudes, the 2*WIDTH accumulator (upper half plus
//          the multiplier shift register as the lower half), the iteration
//          counter and the registered signed product.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   load        capture |mcand|, |mplier|, result sign; clear acc; count=WIDTH
//   step        one shift-add iteration, count decrements
//   finalize    product <= neg ? -acc : acc
//   mcand       signed multiplicand (used on load only)
//   mplier      signed multiplier (used on load only)
//   count_zero  high when the current step takes the counter from 1 to 0
//   product     registered signed 2*WIDTH result
module shift_add_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 finalize,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 count_zero,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_mag;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] mplier_sr;
  logic [CNT_W-1:0] count;
  logic             neg;

  logic [WIDTH-1:0] mcand_abs;
  logic [WIDTH-1:0] mplier_abs;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] acc_full;

  // Two's-complement negate in WIDTH bits; -2^(W-1) maps onto itself, which
  // read as unsigned is exactly its magnitude.
  assign mcand_abs  = mcand[WIDTH-1]  ? (~mcand + 1'b1)  : mcand;
  assign mplier_abs = mplier[WIDTH-1] ? (~mplier + 1'b1) : mplier;

  // Carry-extended partial sum into the upper accumulator half.
  assign sum      = {1'b0, acc_hi} + (mplier_sr[0] ? {1'b0, mcand_mag} : '0);
  assign acc_full = {acc_hi, mplier_sr};

  assign count_zero = step && (count == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_mag <= '0;
      acc_hi    <= '0;
      mplier_sr <= '0;
      count     <= '0;
      neg       <= 1'b0;
      product   <= '0;
    end else begin
      if (load) begin
        mcand_mag <= mcand_abs;
        mplier_sr <= mplier_abs;
        acc_hi    <= '0;
        count     <= CNT_W'(WIDTH);
        neg       <= mcand[WIDTH-1] ^ mplier[WIDTH-1];
      end else if (step) begin
        // {carry, acc_hi, mplier_sr} >> 1
        acc_hi    <= sum[WIDTH:1];
        mplier_sr <= {sum[0], mplier_sr[WIDTH-1:1]};
        count     <= count - CNT_W'(1);
      end
      if (finalize) begin
        product <= neg ? (~acc_full + 1'b1) : acc_full;
      end
    end
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// rtl/seq_mult_ctrl.sv - sequencing controller for the sequential signed multiplier
//
// Purpose: accepts a one-cycle start tick in IDLE, runs WIDTH shift-add
//          iterations, applies the result sign, and pulses done for one cycle.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   start    start tick, honoured only in IDLE
//   mcand    signed multiplicand, sampled on the accepting edge
//   mplier   signed multiplier, sampled on the accepting edge
//   busy     high in RUN, SIGN and DONE
//   done     one-cycle pulse in DONE; product freshly updated
//   product  signed 2*WIDTH result, held until the next completion
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_t state;
  state_t state_next;
  logic   load;
  logic   step;
  logic   finalize;
  logic   count_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finalize   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count_zero) begin
          state_next = SIGN;
        end
      end
      SIGN: begin
        finalize   = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .finalize   (finalize),
    .mcand      (mcand),
    .mplier     (mplier),
    .count_zero (count_zero),
    .product    (product)
  );

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb/tb_seq_mult_ctrl.sv - self-checking bench for seq_mult_ctrl at WIDTH=8
module tb_seq_mult_ctrl;

  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  product;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one operation, scramble the operand inputs afterwards, then expect
  // done exactly W+1 edges after the accepting edge and idle one edge later.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string name);
    int lat;
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    mcand  = ~a;
    mplier = b + 8'd3;
    check({name, "_busy_after_accept"}, 32'(busy), 32'd1);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done) begin
        lat = c;
        break;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'(W + 1));
    check({name, "_product"}, 32'(product), 32'(exp));
    check({name, "_busy_in_done"}, 32'(busy), 32'd1);
    tick();
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    check({name, "_idle_after"}, 32'(busy), 32'd0);
    check({name, "_product_held"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int ndone;
    int last_done;
    int prev_done;
    logic got;

    // Hand-computed 16-bit two's-complement products.
    vecs[0] = '{8'hF9, 8'h06, 16'hFFD6}; // -7 * 6     = -42
    vecs[1] = '{8'h80, 8'h80, 16'h4000}; // -128 * -128 = 16384
    vecs[2] = '{8'h80, 8'h7F, 16'hC080}; // -128 * 127 = -16256
    vecs[3] = '{8'h00, 8'hFB, 16'h0000}; // 0 * -5     = 0
    vecs[4] = '{8'hFF, 8'hFF, 16'h0001}; // -1 * -1    = 1
    vecs[5] = '{8'h7F, 8'h7F, 16'h3F01}; // 127 * 127  = 16129
    vecs[6] = '{8'h05, 8'hFD, 16'hFFF1}; // 5 * -3     = -15
    vecs[7] = '{8'h03, 8'h03, 16'h0009}; // 3 * 3      = 9
    vecs[8] = '{8'h80, 8'h01, 16'hFF80}; // -128 * 1   = -128
    vecs[9] = '{8'h0C, 8'hF5, 16'hFF7C}; // 12 * -11   = -132

    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 4; i++) begin
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_product", 32'(product), 32'd0);
      tick();
    end

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Start re-pulsed during RUN with other operands is ignored.
    mcand  = 8'hF9;
    mplier = 8'h06;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    mcand  = 8'h05;
    mplier = 8'h05;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    ndone  = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) begin
        ndone++;
        check("ignored_start_product", 32'(product), 32'h0000FFD6);
      end
      tick();
    end
    check("ignored_start_done_count", 32'(ndone), 32'd1);
    check("ignored_start_idle", 32'(busy), 32'd0);

    // Reset in the middle of RUN aborts without a done pulse.
    mcand  = 8'h05;
    mplier = 8'h05;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    got = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (done) got = 1'b1;
      tick();
    end
    check("midrst_no_done", 32'(got), 32'd0);
    run_op(8'h03, 8'h03, 16'h0009, "after_rst");

    // rst and start together: reset wins, start lost.
    mcand  = 8'h02;
    mplier = 8'h02;
    start  = 1'b1;
    rst    = 1'b1;
    tick();
    start  = 1'b0;
    rst    = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);

    // Held start: DONE then one IDLE cycle then re-accept -> period W+3 edges.
    mcand     = 8'h05;
    mplier    = 8'hFD;
    start     = 1'b1;
    ndone     = 0;
    prev_done = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        ndone++;
        last_done = i;
        check("b2b_product", 32'(product), 32'h0000FFF1);
        if (prev_done < 0) check("b2b_first_latency", 32'(i), 32'(W + 1));
        else               check("b2b_spacing", 32'(i - prev_done), 32'(W + 3));
        prev_done = last_done;
      end
    end
    start = 1'b0;
    check("b2b_done_count", 32'(ndone), 32'd3);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!busy) begin
        got = 1'b1;
        break;
      end
    end
    check("b2b_drain", 32'(got), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
